rtc_bcd_alarm: RTL and testbench

Parametrised BCD real-time clock with an on-chip prescaler, runtime 12/24-hour display mode, validated time load, alarm compare and day-rollover pulse. It replaces the fixed one-tick-per-clock 24-hour counter. It sits between the system clock domain and the display or CPU register bank. All outputs are registered, packed BCD.

---
 rtl/rtc_bcd_alarm_pkg.sv | 35 +++
 rtl/rtc_bcd_alarm_if.sv | 37 +++
 rtl/bcd_mod_counter.sv | 30 +++
 rtl/rtc_bcd_alarm.sv | 100 ++++++++++
 tb/tb_rtc_bcd_alarm.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_bcd_alarm_pkg.sv
// Shared BCD types, field limits and conversion helpers for the real-time clock.
package rtc_pkg;

    typedef logic [7:0] bcd_t;

    localparam bcd_t MAX_SEC = 8'h59;
    localparam bcd_t MAX_MIN = 8'h59;
    localparam bcd_t MAX_HR  = 8'h23;

    function automatic logic bcd_legal(bcd_t b, bcd_t max);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max);
    endfunction

    // Assumes a legal BCD input; wraps from max to 00.
    function automatic bcd_t bcd_inc(bcd_t v, bcd_t max);
        if (v == max)
            return '0;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Returns {pm, hr12}; goes through binary so the 13..23 -> 01..11 fold needs no BCD borrow logic.
    function automatic logic [8:0] hr24_to_12(bcd_t h);
        logic [7:0] b;
        b = {4'd0, h[7:4]} * 8'd10 + {4'd0, h[3:0]};
        if (b == 8'd0)
            b = 8'd12;
        else if (b > 8'd12)
            b = b - 8'd12;
        return {h >= 8'h12, 4'(b / 8'd10), 4'(b % 8'd10)};
    endfunction

endpackage

// File: rtl/rtc_bcd_alarm_if.sv
// Control/status bundle between the clock core and its host register bank.
interface rtc_bcd_alarm_if;
    import rtc_pkg::*;

    logic run;
    logic mode_12h;
    logic set_valid;
    bcd_t set_sec;
    bcd_t set_min;
    bcd_t set_hr;
    logic set_ack;
    logic set_err;
    logic alarm_wr;
    bcd_t alarm_hr;
    bcd_t alarm_min;
    logic alarm_en;
    logic alarm_clr;
    bcd_t sec;
    bcd_t min;
    bcd_t hr;
    logic pm;
    logic day_tick;
    logic alarm_irq;

    modport slave (
        input  run, mode_12h, set_valid, set_sec, set_min, set_hr,
        input  alarm_wr, alarm_hr, alarm_min, alarm_en, alarm_clr,
        output set_ack, set_err, sec, min, hr, pm, day_tick, alarm_irq
    );

    modport master (
        output run, mode_12h, set_valid, set_sec, set_min, set_hr,
        output alarm_wr, alarm_hr, alarm_min, alarm_en, alarm_clr,
        input  set_ack, set_err, sec, min, hr, pm, day_tick, alarm_irq
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD modulo counter with parallel load; wrap flags the MAX->00 step.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter bcd_t MAX = 8'h59
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t val,
    output logic wrap
);

    bcd_t r_val;

    always_ff @(posedge clk) begin
        if (rst)
            r_val <= '0;
        else if (load)
            r_val <= load_val;
        else if (inc)
            r_val <= bcd_inc(r_val, MAX);
    end

    assign val  = r_val;
    assign wrap = inc & (r_val == MAX);

endmodule

// File: rtl/rtc_bcd_alarm.sv
// BCD real-time clock: prescaler, sec/min/hr24 chain, validated load, 12/24 h display and alarm.
module rtc_bcd_alarm
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic          clk,
    input  logic          rst,
    rtc_bcd_alarm_if.slave bus
);

    localparam int unsigned        PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    bcd_t             r_alarm_hr, r_alarm_min, r_hr;
    logic             r_pm, r_set_ack, r_set_err, r_day_tick, r_alarm_irq;

    logic             w_tick, w_set_legal, w_load, w_inc_sec;
    logic             w_sec_wrap, w_min_wrap, w_hr_wrap, w_match;
    bcd_t             w_sec, w_min, w_hr24, w_min_next, w_hr24_next;
    logic [8:0]       w_disp;

    assign w_tick      = bus.run & (r_pre == PRE_LAST);
    assign w_set_legal = bcd_legal(bus.set_sec, MAX_SEC) &
                         bcd_legal(bus.set_min, MAX_MIN) &
                         bcd_legal(bus.set_hr,  MAX_HR);
    assign w_load      = bus.set_valid & w_set_legal;
    assign w_inc_sec   = w_tick & ~w_load;

    bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
        .clk(clk), .rst(rst), .inc(w_inc_sec), .load(w_load),
        .load_val(bus.set_sec), .val(w_sec), .wrap(w_sec_wrap)
    );

    bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
        .clk(clk), .rst(rst), .inc(w_sec_wrap), .load(w_load),
        .load_val(bus.set_min), .val(w_min), .wrap(w_min_wrap)
    );

    bcd_mod_counter #(.MAX(MAX_HR)) u_hr (
        .clk(clk), .rst(rst), .inc(w_min_wrap), .load(w_load),
        .load_val(bus.set_hr), .val(w_hr24), .wrap(w_hr_wrap)
    );

    // Look-ahead of the counter state so display and alarm register on the same edge as the counters.
    always_comb begin
        w_min_next  = w_sec_wrap ? bcd_inc(w_min, MAX_MIN) : w_min;
        w_hr24_next = w_load ? bus.set_hr :
                      (w_min_wrap ? bcd_inc(w_hr24, MAX_HR) : w_hr24);
        w_match     = bus.alarm_en & w_sec_wrap &
                      (w_min_next == r_alarm_min) & (w_hr24_next == r_alarm_hr);
        w_disp      = hr24_to_12(w_hr24_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre       <= '0;
            r_hr        <= '0;
            r_pm        <= 1'b0;
            r_set_ack   <= 1'b0;
            r_set_err   <= 1'b0;
            r_day_tick  <= 1'b0;
            r_alarm_hr  <= '0;
            r_alarm_min <= '0;
            r_alarm_irq <= 1'b0;
        end else begin
            if (w_load)
                r_pre <= '0;
            else if (bus.run)
                r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);

            r_hr       <= bus.mode_12h ? w_disp[7:0] : w_hr24_next;
            r_pm       <= w_disp[8];
            r_set_ack  <= w_load;
            r_set_err  <= bus.set_valid & ~w_set_legal;
            r_day_tick <= w_hr_wrap;

            if (bus.alarm_wr) begin
                r_alarm_hr  <= bus.alarm_hr;
                r_alarm_min <= bus.alarm_min;
            end

            if (w_match)
                r_alarm_irq <= 1'b1;
            else if (bus.alarm_clr)
                r_alarm_irq <= 1'b0;
        end
    end

    assign bus.sec       = w_sec;
    assign bus.min       = w_min;
    assign bus.hr        = r_hr;
    assign bus.pm        = r_pm;
    assign bus.set_ack   = r_set_ack;
    assign bus.set_err   = r_set_err;
    assign bus.day_tick  = r_day_tick;
    assign bus.alarm_irq = r_alarm_irq;

endmodule

// File: tb/tb_rtc_bcd_alarm.sv
// Bench for rtc_bcd_alarm: two instances (TICK_DIV 1 and 4) against a seconds-of-day reference model.
module tb_rtc_bcd_alarm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rtc_bcd_alarm_if bus1 ();
    rtc_bcd_alarm_if bus4 ();

    rtc_bcd_alarm #(.TICK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    rtc_bcd_alarm #(.TICK_DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.run       = bus1.run;
    assign bus4.mode_12h  = bus1.mode_12h;
    assign bus4.set_valid = bus1.set_valid;
    assign bus4.set_sec   = bus1.set_sec;
    assign bus4.set_min   = bus1.set_min;
    assign bus4.set_hr    = bus1.set_hr;
    assign bus4.alarm_wr  = bus1.alarm_wr;
    assign bus4.alarm_hr  = bus1.alarm_hr;
    assign bus4.alarm_min = bus1.alarm_min;
    assign bus4.alarm_en  = bus1.alarm_en;
    assign bus4.alarm_clr = bus1.alarm_clr;

    logic [28:0] o_all [2];
    assign o_all[0] = {bus1.sec, bus1.min, bus1.hr, bus1.pm, bus1.set_ack, bus1.set_err, bus1.day_tick, bus1.alarm_irq};
    assign o_all[1] = {bus4.sec, bus4.min, bus4.hr, bus4.pm, bus4.set_ack, bus4.set_err, bus4.day_tick, bus4.alarm_irq};

    int n_vec = 0;
    int n_err = 0;

    // Reference state: time as seconds-of-day, alarm as minute-of-day (-1 = can never match).
    int   m_t   [2];
    int   m_pre [2];
    bit   m_irq [2];
    bit   m_ack [2];
    bit   m_err [2];
    bit   m_day [2];
    bit   e_pm  [2];
    logic [7:0] e_hr [2];
    int   m_alarm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int bcd2int(logic [7:0] b, int max);
        int v;
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9)
            return -1;
        v = int'(b[7:4]) * 10 + int'(b[3:0]);
        return (v <= max) ? v : -1;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    task automatic model_step();
        int  s, m, h, nt, h24, ah, am;
        bit  legal, tick, match;
        s = bcd2int(bus1.set_sec, 59);
        m = bcd2int(bus1.set_min, 59);
        h = bcd2int(bus1.set_hr, 23);
        legal = (s >= 0) && (m >= 0) && (h >= 0);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_t[k] = 0; m_pre[k] = 0; m_irq[k] = 0;
                m_ack[k] = 0; m_err[k] = 0; m_day[k] = 0;
                e_hr[k] = 8'h00; e_pm[k] = 0;
            end else begin
                tick  = bus1.run && (m_pre[k] == div_of(k) - 1);
                m_ack[k] = bus1.set_valid && legal;
                m_err[k] = bus1.set_valid && !legal;
                m_day[k] = 0;
                match = 0;
                if (m_ack[k]) begin
                    m_t[k]   = h * 3600 + m * 60 + s;
                    m_pre[k] = 0;
                end else begin
                    if (bus1.run)
                        m_pre[k] = tick ? 0 : m_pre[k] + 1;
                    if (tick) begin
                        nt = (m_t[k] + 1) % 86400;
                        m_day[k] = (nt == 0);
                        match = bus1.alarm_en && (nt % 60 == 0) && (m_alarm >= 0) && (nt / 60 == m_alarm);
                        m_t[k] = nt;
                    end
                end
                if (match)
                    m_irq[k] = 1;
                else if (bus1.alarm_clr)
                    m_irq[k] = 0;
                h24 = m_t[k] / 3600;
                e_pm[k] = (h24 >= 12);
                e_hr[k] = bus1.mode_12h ? to_bcd((h24 % 12 == 0) ? 12 : h24 % 12) : to_bcd(h24);
            end
        end
        if (rst)
            m_alarm = 0;
        else if (bus1.alarm_wr) begin
            ah = bcd2int(bus1.alarm_hr, 23);
            am = bcd2int(bus1.alarm_min, 59);
            m_alarm = (ah >= 0 && am >= 0) ? ah * 60 + am : -1;
        end
    endtask

    task automatic compare_all();
        logic [28:0] o;
        string p;
        for (int k = 0; k < 2; k++) begin
            o = o_all[k];
            p = $sformatf("div%0d.", div_of(k));
            check({p, "sec"},   32'(o[28:21]), 32'(to_bcd(m_t[k] % 60)));
            check({p, "min"},   32'(o[20:13]), 32'(to_bcd((m_t[k] / 60) % 60)));
            check({p, "hr"},    32'(o[12:5]),  32'(e_hr[k]));
            check({p, "pm"},    32'(o[4]),     32'(e_pm[k]));
            check({p, "ack"},   32'(o[3]),     32'(m_ack[k]));
            check({p, "err"},   32'(o[2]),     32'(m_err[k]));
            check({p, "day"},   32'(o[1]),     32'(m_day[k]));
            check({p, "irq"},   32'(o[0]),     32'(m_irq[k]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus1.set_valid = 1'b1;
        bus1.set_hr = h; bus1.set_min = m; bus1.set_sec = s;
        cycle();
        bus1.set_valid = 1'b0;
    endtask

    logic [7:0] hr_in  [4] = '{8'h00, 8'h12, 8'h13, 8'h23};
    logic [7:0] hr_exp [4] = '{8'h12, 8'h12, 8'h01, 8'h11};
    bit         pm_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int mm;
        rst = 1'b1;
        bus1.run = 1'b0; bus1.mode_12h = 1'b0; bus1.set_valid = 1'b0;
        bus1.set_sec = '0; bus1.set_min = '0; bus1.set_hr = '0;
        bus1.alarm_wr = 1'b0; bus1.alarm_hr = '0; bus1.alarm_min = '0;
        bus1.alarm_en = 1'b0; bus1.alarm_clr = 1'b0;
        m_alarm = 0;

        cycle();
        cycle();
        check("rst_hr", 32'(bus1.hr), 32'h00);
        check("rst_sec", 32'(bus1.sec), 32'h00);
        rst = 1'b0;
        repeat (2) cycle();

        bus1.run = 1'b1;
        do_set(8'h23, 8'h59, 8'h59);
        cycle();
        check("roll_day", 32'(bus1.day_tick), 32'd1);
        check("roll_hr", 32'(bus1.hr), 32'h00);
        cycle();
        check("roll_day_once", 32'(bus1.day_tick), 32'd0);
        repeat (5) cycle();

        bus1.run = 1'b0;
        bus1.mode_12h = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_set(hr_in[i], 8'h15, 8'h30);
            check("map12_hr", 32'(bus1.hr), 32'(hr_exp[i]));
            check("map12_pm", 32'(bus1.pm), 32'(pm_exp[i]));
        end
        bus1.mode_12h = 1'b0;
        cycle();

        do_set(8'h10, 8'h20, 8'h60);
        check("bad60_err", 32'(bus1.set_err), 32'd1);
        check("bad60_sec", 32'(bus1.sec), 32'h30);
        do_set(8'h10, 8'h20, 8'h0A);
        check("bad0A_ack", 32'(bus1.set_ack), 32'd0);
        cycle();

        bus1.alarm_wr = 1'b1; bus1.alarm_hr = 8'h07; bus1.alarm_min = 8'h30;
        cycle();
        bus1.alarm_wr = 1'b0;
        bus1.alarm_en = 1'b1;
        bus1.run = 1'b1;
        do_set(8'h07, 8'h29, 8'h58);
        cycle();
        bus1.alarm_clr = 1'b1;
        cycle();
        check("alarm_set_wins", 32'(bus1.alarm_irq), 32'd1);
        bus1.alarm_clr = 1'b0;
        repeat (8) cycle();
        bus1.alarm_clr = 1'b1;
        cycle();
        check("alarm_clr", 32'(bus1.alarm_irq), 32'd0);
        bus1.alarm_clr = 1'b0;
        do_set(8'h07, 8'h30, 8'h00);
        check("alarm_on_set", 32'(bus1.alarm_irq), 32'd0);

        repeat (12) cycle();
        bus1.run = 1'b0;
        repeat (10) cycle();
        bus1.run = 1'b1;
        for (int i = 0; i < 8 && m_pre[1] != 3; i++)
            cycle();
        do_set(8'h12, 8'h34, 8'h56);
        check("pre_set_sec", 32'(bus4.sec), 32'h56);
        repeat (6) cycle();

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            bus1.run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 63) == 0)
                bus1.mode_12h = ~bus1.mode_12h;
            bus1.set_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0: begin
                    bus1.set_hr  = to_bcd($urandom_range(0, 23));
                    bus1.set_min = to_bcd($urandom_range(0, 59));
                    bus1.set_sec = to_bcd($urandom_range(0, 59));
                end
                1: begin
                    bus1.set_hr  = 8'h23;
                    bus1.set_min = 8'h59;
                    bus1.set_sec = to_bcd($urandom_range(50, 59));
                end
                default: begin
                    bus1.set_hr  = 8'($urandom);
                    bus1.set_min = 8'($urandom);
                    bus1.set_sec = 8'($urandom);
                end
            endcase
            bus1.alarm_wr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus1.alarm_hr  = 8'($urandom);
                bus1.alarm_min = 8'($urandom);
            end else begin
                mm = (m_t[0] / 60 + 1) % 1440;
                bus1.alarm_hr  = to_bcd(mm / 60);
                bus1.alarm_min = to_bcd(mm % 60);
            end
            bus1.alarm_en  = ($urandom_range(0, 7) != 0);
            bus1.alarm_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
